cn_crossbar_arb: RTL and testbench

- Completer-side crossbar node that connects NUM_REQ requester channels to one APB completer channel.
- The next generation of the completer node: the channel count is parametrised, and a round-robin arbiter is built in, replacing the external `sel`.
- Adds explicit SETUP/ACCESS sequencing toward the completer, masking of completed requests, and a PREADY watchdog that returns an error response.
- Sits between the interconnect request/response fabric and each APB completer.

---
 rtl/cn_crossbar_arb_pkg.sv | 24 ++
 rtl/cn_rr_arbiter.sv | 31 +++
 rtl/cn_crossbar_arb.sv | 165 ++++++++++++++++
 tb/tb_cn_crossbar_arb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cn_crossbar_arb_pkg.sv
// Shared definitions for the completer-side crossbar node: default flit
// widths, APB control bit positions inside the flits and the FSM encoding.
package cn_crossbar_arb_pkg;

    // Default flit widths used when the instantiating node does not override them
    localparam int CN_REQ_FLIT_W = 8;
    localparam int CN_RSP_FLIT_W = 8;

    // Request flit control bits
    localparam int PSEL_BIT    = 0;
    localparam int PENABLE_BIT = 1;

    // Response flit control bits
    localparam int PREADY_BIT  = 0;
    localparam int PSLVERR_BIT = 1;

    // Node sequencing toward the completer
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } cn_state_e;

endpackage

// File: rtl/cn_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible channel
// searching upward from last_grant+1, wrapping modulo NUM_REQ.
module cn_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               any_valid,
    output logic [GRANT_W-1:0] winner
);

    // Rotating priority search; the first hit after last_grant is kept
    always_comb begin
        logic               found_v;
        logic [GRANT_W-1:0] idx_v;
        logic               hit_v;
        found_v = 1'b0;
        idx_v   = '0;
        hit_v   = 1'b0;
        winner  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v   = GRANT_W'((int'(last_grant) + k) % NUM_REQ);
            hit_v   = eligible[idx_v] && !found_v;
            winner  = hit_v ? idx_v : winner;
            found_v = found_v | eligible[idx_v];
        end
        any_valid = found_v;
    end

endmodule

// File: rtl/cn_crossbar_arb.sv
// Completer-side crossbar node: arbitrates NUM_REQ requester channels onto
// one APB completer, sequences SETUP/ACCESS, masks finished requests and
// returns an error response when the completer never raises PREADY.
module cn_crossbar_arb
    import cn_crossbar_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int REQ_FLIT_WIDTH = CN_REQ_FLIT_W,
    parameter int RSP_FLIT_WIDTH = CN_RSP_FLIT_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int GRANT_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ*REQ_FLIT_WIDTH-1:0]  icn_rxreq,
    output logic [NUM_REQ*RSP_FLIT_WIDTH-1:0]  icn_txrsp,
    output logic [REQ_FLIT_WIDTH-1:0]          comp_req,
    input  logic [RSP_FLIT_WIDTH-1:0]          comp_rsp,
    output logic [GRANT_W-1:0]                 grant_id,
    output logic                               busy,
    output logic                               timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [RSP_FLIT_WIDTH-1:0] ERR_RSP =
        (RSP_FLIT_WIDTH'(1) << PREADY_BIT) | (RSP_FLIT_WIDTH'(1) << PSLVERR_BIT);

    cn_state_e                          state_r, state_n;
    logic [GRANT_W-1:0]                 grant_r, grant_n;
    logic [GRANT_W-1:0]                 last_grant_r, last_grant_n;
    logic [NUM_REQ-1:0]                 stale_r, stale_n;
    logic [CNT_W-1:0]                   cnt_r, cnt_n;
    logic [REQ_FLIT_WIDTH-1:0]          comp_req_r, comp_req_n;
    logic [NUM_REQ*RSP_FLIT_WIDTH-1:0]  txrsp_r, txrsp_n;
    logic                               busy_r, busy_n;
    logic                               tmo_r, tmo_n;

    logic [REQ_FLIT_WIDTH-1:0]          req_flit_s [NUM_REQ];
    logic [NUM_REQ-1:0]                 psel_s;
    logic [NUM_REQ-1:0]                 penable_s;
    logic [NUM_REQ-1:0]                 stale_eff_s;
    logic [NUM_REQ-1:0]                 eligible_s;
    logic [NUM_REQ-1:0]                 stale_set_s;
    logic                               any_valid_s;
    logic [GRANT_W-1:0]                 winner_s;
    logic                               pready_s;
    logic                               timeout_s;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_flit_s[i] = icn_rxreq[i*REQ_FLIT_WIDTH +: REQ_FLIT_WIDTH];
        assign psel_s[i]     = icn_rxreq[i*REQ_FLIT_WIDTH + PSEL_BIT];
        assign penable_s[i]  = icn_rxreq[i*REQ_FLIT_WIDTH + PENABLE_BIT];
    end

    // A stale mark survives only while the channel still shows PSEL=1, PENABLE=1,
    // so a back-to-back SETUP flit is eligible in the very cycle it appears
    assign stale_eff_s = stale_r & psel_s & penable_s;
    assign eligible_s  = psel_s & ~stale_eff_s;

    assign pready_s  = comp_rsp[PREADY_BIT];
    assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LAST) && !pready_s;

    cn_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_arb (
        .eligible   (eligible_s),
        .last_grant (last_grant_r),
        .any_valid  (any_valid_s),
        .winner     (winner_s)
    );

    // Next-state and next-output computation for the transfer sequencer
    always_comb begin
        state_n      = state_r;
        grant_n      = grant_r;
        last_grant_n = last_grant_r;
        cnt_n        = cnt_r;
        comp_req_n   = comp_req_r;
        txrsp_n      = '0;
        busy_n       = busy_r;
        tmo_n        = 1'b0;
        stale_set_s  = '0;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    grant_n                 = winner_s;
                    comp_req_n              = req_flit_s[winner_s];
                    comp_req_n[PENABLE_BIT] = 1'b0;
                    busy_n                  = 1'b1;
                    state_n                 = ST_SETUP;
                end else begin
                    comp_req_n = '0;
                    busy_n     = 1'b0;
                end
            end
            ST_SETUP: begin
                comp_req_n              = req_flit_s[grant_r];
                comp_req_n[PENABLE_BIT] = 1'b1;
                cnt_n                   = '0;
                state_n                 = ST_ACCESS;
            end
            ST_ACCESS: begin
                txrsp_n[int'(grant_r)*RSP_FLIT_WIDTH +: RSP_FLIT_WIDTH] = comp_rsp;
                cnt_n = cnt_r + CNT_W'(1);
                if (pready_s || timeout_s) begin
                    // PREADY has priority: timeout_s is already false when PREADY=1
                    if (timeout_s) begin
                        txrsp_n[int'(grant_r)*RSP_FLIT_WIDTH +: RSP_FLIT_WIDTH] = ERR_RSP;
                        tmo_n = 1'b1;
                    end else begin
                        tmo_n = 1'b0;
                    end
                    comp_req_n           = '0;
                    last_grant_n         = grant_r;
                    stale_set_s[grant_r] = 1'b1;
                    busy_n               = 1'b0;
                    state_n              = ST_IDLE;
                end else begin
                    state_n = ST_ACCESS;
                end
            end
            default: begin
                comp_req_n = '0;
                busy_n     = 1'b0;
                state_n    = ST_IDLE;
            end
        endcase
        stale_n = stale_eff_s | stale_set_s;
    end

    // State and registered-output update with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= GRANT_W'(NUM_REQ - 1);
            stale_r      <= '0;
            cnt_r        <= '0;
            comp_req_r   <= '0;
            txrsp_r      <= '0;
            busy_r       <= 1'b0;
            tmo_r        <= 1'b0;
        end else begin
            state_r      <= state_n;
            grant_r      <= grant_n;
            last_grant_r <= last_grant_n;
            stale_r      <= stale_n;
            cnt_r        <= cnt_n;
            comp_req_r   <= comp_req_n;
            txrsp_r      <= txrsp_n;
            busy_r       <= busy_n;
            tmo_r        <= tmo_n;
        end
    end

    assign icn_txrsp   = txrsp_r;
    assign comp_req    = comp_req_r;
    assign grant_id    = grant_r;
    assign busy        = busy_r;
    assign timeout_err = tmo_r;

endmodule

// File: tb/tb_cn_crossbar_arb.sv
// Directed bench for cn_crossbar_arb: 4 channels, 8-bit flits, 4-cycle watchdog.
// Request flit: bit0 PSEL, bit1 PENABLE. Response flit: bit0 PREADY, bit1 PSLVERR.
module tb_cn_crossbar_arb;

    localparam int NREQ = 4;
    localparam int RW   = 8;
    localparam int SW   = 8;
    localparam int GW   = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ*RW-1:0] icn_rxreq;
    logic [NREQ*SW-1:0] icn_txrsp;
    logic [RW-1:0]     comp_req;
    logic [SW-1:0]     comp_rsp;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              timeout_err;

    int checks;
    int errors;

    cn_crossbar_arb #(
        .NUM_REQ        (NREQ),
        .REQ_FLIT_WIDTH (RW),
        .RSP_FLIT_WIDTH (SW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .icn_rxreq   (icn_rxreq),
        .icn_txrsp   (icn_txrsp),
        .comp_req    (comp_req),
        .comp_rsp    (comp_rsp),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [7:0] flit);
        icn_rxreq[ch*RW +: RW] = flit;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        icn_rxreq = '0;
        comp_rsp  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] order [4];
        checks = 0;
        errors = 0;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd0;

        // Reset state
        do_reset();
        check_eq("rst_comp_req", 32'(comp_req), 32'h0);
        check_eq("rst_txrsp", icn_txrsp, 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_grant", 32'(grant_id), 32'h0);
        check_eq("rst_tmo", 32'(timeout_err), 32'h0);

        // Single request on channel 2, PREADY on second ACCESS cycle
        set_req(2, 8'h55);
        step();
        check_eq("t1_setup_req", 32'(comp_req), 32'h55);
        check_eq("t1_grant", 32'(grant_id), 32'h2);
        check_eq("t1_busy", 32'(busy), 32'h1);
        set_req(2, 8'h57);
        step();
        check_eq("t1_access_req", 32'(comp_req), 32'h57);
        step();
        check_eq("t1_wait_txrsp", icn_txrsp, 32'h0);
        check_eq("t1_wait_busy", 32'(busy), 32'h1);
        comp_rsp = 8'h31;
        step();
        check_eq("t1_rsp", icn_txrsp, 32'h0031_0000);
        check_eq("t1_done_req", 32'(comp_req), 32'h0);
        check_eq("t1_done_busy", 32'(busy), 32'h0);
        check_eq("t1_tmo", 32'(timeout_err), 32'h0);
        icn_rxreq = '0;
        comp_rsp  = 8'h00;
        step();
        check_eq("t1_idle_txrsp", icn_txrsp, 32'h0);

        // Channels 0,1,3 hold SETUP flits; completer always ready
        do_reset();
        set_req(0, 8'h11);
        set_req(1, 8'h21);
        set_req(3, 8'h41);
        comp_rsp = 8'h01;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("t2_grant%0d", k), 32'(grant_id), 32'(order[k]));
            check_eq($sformatf("t2_busy%0d", k), 32'(busy), 32'h1);
            step();
            step();
            check_eq($sformatf("t2_rsp%0d", k), icn_txrsp, 32'h1 << (8 * int'(order[k])));
            check_eq($sformatf("t2_idle%0d", k), 32'(busy), 32'h0);
        end
        icn_rxreq = '0;
        comp_rsp  = 8'h00;
        step();
        step();

        // Stale masking on channel 1 (last_grant is 0 here)
        set_req(1, 8'h21);
        step();
        check_eq("t3_grant", 32'(grant_id), 32'h1);
        set_req(1, 8'h23);
        step();
        comp_rsp = 8'h01;
        step();
        check_eq("t3_done", 32'(busy), 32'h0);
        comp_rsp = 8'h00;
        step();
        check_eq("t3_stale_a", 32'(busy), 32'h0);
        step();
        check_eq("t3_stale_b", 32'(busy), 32'h0);
        set_req(1, 8'h21);
        step();
        check_eq("t3_regrant_busy", 32'(busy), 32'h1);
        check_eq("t3_regrant_id", 32'(grant_id), 32'h1);
        step();
        comp_rsp = 8'h01;
        step();
        icn_rxreq = '0;
        comp_rsp  = 8'h00;
        step();

        // Watchdog: channel 3, PREADY held low with nonzero data
        set_req(3, 8'h43);
        comp_rsp = 8'hF0;
        step();
        check_eq("t4_grant", 32'(grant_id), 32'h3);
        check_eq("t4_setup_pen0", 32'(comp_req), 32'h41);
        step();
        check_eq("t4_access_pen1", 32'(comp_req), 32'h43);
        step();
        check_eq("t4_pass_rsp", icn_txrsp, 32'hF000_0000);
        check_eq("t4_no_tmo_yet", 32'(timeout_err), 32'h0);
        step();
        step();
        check_eq("t4_still_busy", 32'(busy), 32'h1);
        step();
        check_eq("t4_tmo_pulse", 32'(timeout_err), 32'h1);
        check_eq("t4_err_rsp", icn_txrsp, 32'h0300_0000);
        check_eq("t4_req_cleared", 32'(comp_req), 32'h0);
        check_eq("t4_busy", 32'(busy), 32'h0);
        icn_rxreq = '0;
        comp_rsp  = 8'h00;
        step();
        check_eq("t4_tmo_one_cycle", 32'(timeout_err), 32'h0);

        // PREADY on the last allowed ACCESS cycle: normal response
        set_req(0, 8'h13);
        step();
        check_eq("t5_grant", 32'(grant_id), 32'h0);
        step();
        step();
        step();
        step();
        comp_rsp = 8'h81;
        step();
        check_eq("t5_rsp", icn_txrsp, 32'h0000_0081);
        check_eq("t5_no_tmo", 32'(timeout_err), 32'h0);
        check_eq("t5_busy", 32'(busy), 32'h0);
        icn_rxreq = '0;
        comp_rsp  = 8'h00;
        step();

        // Asynchronous reset in the middle of ACCESS
        icn_rxreq = 32'h0101_0101;
        step();
        check_eq("t6_grant", 32'(grant_id), 32'h1);
        comp_rsp = 8'h50;
        step();
        step();
        check_eq("t6_mid_busy", 32'(busy), 32'h1);
        check_eq("t6_mid_txrsp", icn_txrsp, 32'h0000_5000);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_req", 32'(comp_req), 32'h0);
        check_eq("t6_async_txrsp", icn_txrsp, 32'h0);
        check_eq("t6_async_busy", 32'(busy), 32'h0);
        check_eq("t6_async_grant", 32'(grant_id), 32'h0);
        comp_rsp = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("t6_post_grant", 32'(grant_id), 32'h0);
        check_eq("t6_post_busy", 32'(busy), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
